// File: rtl/clock_pkg.sv
// Shared definitions for the multi-channel clock divider: channel state
// encoding and the divisor every channel starts from after reset.
package clock_pkg;

    // Channel life cycle: stopped, producing periods, finishing the last period.
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_RUN   = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_e;

    // 50 MHz system clock divided down to 10 kHz.
    localparam int DIV_INIT_DEFAULT = 5000;

endpackage

// File: rtl/clock_div_channel.sv
// One divided-clock channel. Keeps an active divisor and a pending divisor;
// the pending value only takes effect on a period boundary so that no high
// or low phase is ever cut short. All outputs come straight from flops.
module clock_div_channel
    import clock_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int DIV_INIT = DIV_INIT_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_val_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             busy_o
);

    // A divisor of 1 cannot give a high and a low phase, so it runs as 2.
    function automatic logic [DIV_W-1:0] norm_div(input logic [DIV_W-1:0] v);
        if (v == DIV_W'(1)) begin
            return DIV_W'(2);
        end
        return v;
    endfunction

    // ceil(d/2) with one spare bit so the all-ones divisor cannot overflow.
    function automatic logic [DIV_W:0] half_up(input logic [DIV_W-1:0] d);
        logic [DIV_W:0] sum;
        sum = {1'b0, d} + (DIV_W+1)'(1);
        return sum >> 1;
    endfunction

    localparam logic [DIV_W-1:0] D_RST = norm_div(DIV_W'(DIV_INIT));

    ch_state_e        state_q;
    logic [DIV_W-1:0] d_q;
    logic [DIV_W-1:0] p_q;
    logic             pending_q;
    logic [DIV_W-1:0] cnt_q;
    logic             clk_q;
    logic             tick_q;
    logic             busy_q;

    logic [DIV_W-1:0] div_ld;
    logic [DIV_W-1:0] cnt_inc;
    logic             wrap;
    logic [DIV_W-1:0] idle_div_d;
    logic [DIV_W-1:0] bnd_div_d;
    logic             hi_next;

    // Normalised divisor captured by a load strobe this cycle.
    assign div_ld     = norm_div(div_val_i);
    assign cnt_inc    = cnt_q + DIV_W'(1);
    // Last cycle of the current period; only meaningful while running (D >= 2).
    assign wrap       = (cnt_q == d_q - DIV_W'(1));
    // While stopped a new divisor takes effect at once, a leftover pending one too.
    assign idle_div_d = load_i ? div_ld : (pending_q ? p_q : d_q);
    // A load arriving on the boundary wins: it replaces P and waits one more period.
    assign bnd_div_d  = (!load_i && pending_q) ? p_q : d_q;
    // High phase covers counts 0 .. ceil(D/2)-1 of the period.
    assign hi_next    = ({1'b0, cnt_inc} < half_up(d_q));

    // Channel FSM with divisor bookkeeping and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= CH_IDLE;
            d_q       <= D_RST;
            p_q       <= D_RST;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                CH_IDLE: begin
                    d_q       <= idle_div_d;
                    pending_q <= 1'b0;
                    cnt_q     <= '0;
                    if (load_i) begin
                        p_q <= div_ld;
                    end
                    if (en_i && (idle_div_d >= DIV_W'(2))) begin
                        state_q <= CH_RUN;
                        clk_q   <= 1'b1;
                        tick_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        clk_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                CH_RUN, CH_DRAIN: begin
                    if (wrap) begin
                        d_q       <= bnd_div_d;
                        pending_q <= load_i;
                        cnt_q     <= '0;
                        if (load_i) begin
                            p_q <= div_ld;
                        end
                        // Start the next period only if still enabled and the
                        // divisor now in force is not the stop value 0.
                        if (en_i && (bnd_div_d >= DIV_W'(2))) begin
                            state_q <= CH_RUN;
                            clk_q   <= 1'b1;
                            tick_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= CH_IDLE;
                            clk_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                        if (load_i) begin
                            p_q       <= div_ld;
                            pending_q <= 1'b1;
                        end
                        // Dropping en only marks the period as the last one;
                        // raising it again before the boundary resumes seamlessly.
                        state_q <= en_i ? CH_RUN : CH_DRAIN;
                        clk_q   <= hi_next;
                        busy_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= CH_IDLE;
                    cnt_q   <= '0;
                    clk_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/multi_clock_generator.sv
// Bank of N_CH independent programmable clock dividers running from one
// system clock. Each channel has its own enable, load strobe and divisor.
module multi_clock_generator
    import clock_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DIV_W    = 16,
    parameter int DIV_INIT = DIV_INIT_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       load,
    input  logic [N_CH*DIV_W-1:0] div_val,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       busy
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clock_div_channel #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk_i     (clk_in),
            .rst_ni    (rst_n),
            .en_i      (en[i]),
            .load_i    (load[i]),
            .div_val_i (div_val[i*DIV_W +: DIV_W]),
            .clk_o     (clk_out[i]),
            .tick_o    (tick[i]),
            .busy_o    (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_clock_generator.sv
// Bench for multi_clock_generator: directed scenarios followed by random
// enable/load traffic, compared every cycle against a position-in-period model.
module tb_multi_clock_generator;

    localparam int N_CH     = 4;
    localparam int DIV_W    = 16;
    localparam int DIV_INIT = 5000;

    logic                  clk_in = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       load;
    logic [N_CH*DIV_W-1:0] div_val;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       busy;

    always #5 clk_in = ~clk_in;

    multi_clock_generator #(
        .N_CH     (N_CH),
        .DIV_W    (DIV_W),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .div_val (div_val),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    // Reference model: each channel is either stopped or at position pos
    // within a period of length per; output is high while 2*pos < per.
    int              m_act [N_CH];
    int              m_per [N_CH];
    int              m_pv  [N_CH];
    int              m_pnd [N_CH];
    int              m_pos [N_CH];
    logic [N_CH-1:0] e_clk, e_tick, e_busy;

    int n_pass = 0;
    int n_chk  = 0;

    function automatic int fix_div(int v);
        return (v == 1) ? 2 : v;
    endfunction

    task automatic model_edge();
        for (int c = 0; c < N_CH; c++) begin
            int dv;
            dv = fix_div(int'(div_val[c*DIV_W +: DIV_W]));
            if (!rst_n) begin
                m_act[c] = 0; m_per[c] = DIV_INIT; m_pv[c] = DIV_INIT;
                m_pnd[c] = 0; m_pos[c] = 0;
                e_clk[c] = 1'b0; e_tick[c] = 1'b0; e_busy[c] = 1'b0;
            end else if (m_act[c] == 0) begin
                if (load[c]) begin
                    m_per[c] = dv; m_pv[c] = dv; m_pnd[c] = 0;
                end else if (m_pnd[c] != 0) begin
                    m_per[c] = m_pv[c]; m_pnd[c] = 0;
                end
                if (en[c] && m_per[c] >= 2) begin
                    m_act[c] = 1; m_pos[c] = 0;
                    e_clk[c] = 1'b1; e_tick[c] = 1'b1; e_busy[c] = 1'b1;
                end else begin
                    e_clk[c] = 1'b0; e_tick[c] = 1'b0; e_busy[c] = 1'b0;
                end
            end else if (m_pos[c] == m_per[c] - 1) begin
                if (load[c]) begin
                    m_pv[c] = dv; m_pnd[c] = 1;
                end else if (m_pnd[c] != 0) begin
                    m_per[c] = m_pv[c]; m_pnd[c] = 0;
                end
                m_pos[c] = 0;
                if (!en[c] || m_per[c] < 2) begin
                    m_act[c] = 0;
                    e_clk[c] = 1'b0; e_tick[c] = 1'b0; e_busy[c] = 1'b0;
                end else begin
                    e_clk[c] = 1'b1; e_tick[c] = 1'b1; e_busy[c] = 1'b1;
                end
            end else begin
                if (load[c]) begin
                    m_pv[c] = dv; m_pnd[c] = 1;
                end
                m_pos[c] = m_pos[c] + 1;
                e_clk[c]  = (2 * m_pos[c] < m_per[c]);
                e_tick[c] = 1'b0;
                e_busy[c] = 1'b1;
            end
        end
    endtask

    task automatic check_vec(string tag, logic [N_CH-1:0] got, logic [N_CH-1:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic check_int(string tag, int got, int exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        check_vec("clk_out", clk_out, e_clk);
        check_vec("tick", tick, e_tick);
        check_vec("busy", busy, e_busy);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic set_div(int c, int v);
        div_val[c*DIV_W +: DIV_W] = v[DIV_W-1:0];
    endtask

    task automatic pulse_load(int c, int v);
        set_div(c, v);
        load[c] = 1'b1;
        step();
        load[c] = 1'b0;
    endtask

    task automatic wait_pos(int c, int p);
        int guard;
        guard = 0;
        while (m_pos[c] != p && guard < 70000) begin
            step();
            guard++;
        end
        check_int("wait_pos_bound", int'(guard < 70000), 1);
    endtask

    initial begin
        int hi, tk, guard;
        for (int c = 0; c < N_CH; c++) begin
            m_act[c] = 0; m_per[c] = DIV_INIT; m_pv[c] = DIV_INIT;
            m_pnd[c] = 0; m_pos[c] = 0;
        end
        e_clk = '0; e_tick = '0; e_busy = '0;
        rst_n = 1'b0; en = '0; load = '0; div_val = '0;

        // Reset with noisy inputs that must be ignored.
        step();
        en = '1; load = '1; div_val = {N_CH{16'd3}};
        run(2);
        check_vec("reset_clk", clk_out, '0);
        check_vec("reset_busy", busy, '0);
        en = '0; load = '0; div_val = '0;
        rst_n = 1'b1;
        run(2);

        // Channel 0 on the reset divisor: 2500 high, 2500 low, one tick per period.
        en[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            hi = 0; tk = 0;
            repeat (5000) begin
                step();
                hi += int'(clk_out[0]);
                tk += int'(tick[0]);
            end
            check_int("ch0_high_cycles", hi, 2500);
            check_int("ch0_ticks", tk, 1);
        end

        // Channel 1: divisor 4, then 7 loaded mid-period.
        pulse_load(1, 4);
        en[1] = 1'b1;
        run(6);
        wait_pos(1, 1);
        pulse_load(1, 7);
        run(30);
        hi = 0;
        wait_pos(1, 0);
        repeat (7) begin
            hi += int'(clk_out[1]);
            step();
        end
        check_int("ch1_d7_high", hi, 4);

        // Channel 2: divisor 6, drop enable at count 1.
        pulse_load(2, 6);
        en[2] = 1'b1;
        run(8);
        wait_pos(2, 1);
        en[2] = 1'b0;
        hi = 0;
        repeat (4) begin
            step();
            hi += int'(busy[2]);
        end
        check_int("ch2_drain_busy", hi, 4);
        step();
        check_int("ch2_idle_busy", int'(busy[2]), 0);
        check_int("ch2_idle_clk", int'(clk_out[2]), 0);
        // Drop at count 1, restore at count 3: no gap.
        en[2] = 1'b1;
        run(3);
        wait_pos(2, 1);
        en[2] = 1'b0;
        run(2);
        en[2] = 1'b1;
        hi = 0;
        repeat (12) begin
            step();
            hi += int'(busy[2]);
        end
        check_int("ch2_nogap_busy", hi, 12);

        // Channel 3: divisor 0 stops at the boundary, divisor 1 runs as 2.
        pulse_load(3, 5);
        en[3] = 1'b1;
        run(3);
        pulse_load(3, 0);
        run(10);
        check_int("ch3_stopped", int'(busy[3]), 0);
        pulse_load(3, 1);
        hi = 0;
        repeat (10) begin
            step();
            hi += int'(clk_out[3]);
        end
        check_int("ch3_d1_high", hi, 5);

        // Reset pulse during channel 0's high phase.
        guard = 0;
        while (!(e_clk[0] && m_pos[0] > 10) && guard < 6000) begin
            step();
            guard++;
        end
        check_int("ch0_high_bound", int'(guard < 6000), 1);
        rst_n = 1'b0;
        step();
        check_vec("midreset_clk", clk_out, '0);
        check_vec("midreset_tick", tick, '0);
        check_vec("midreset_busy", busy, '0);
        rst_n = 1'b1;
        run(20);
        rst_n = 1'b0; en = '0;
        step();
        rst_n = 1'b1;
        step();

        // All channels at once: 2, 3, 4, 65535.
        set_div(0, 2); set_div(1, 3); set_div(2, 4); set_div(3, 65535);
        load = '1;
        step();
        load = '0;
        en = '1;
        tk = 0;
        repeat (12) begin
            step();
            tk += int'(tick[1]);
        end
        check_int("ch1_d3_ticks", tk, 4);
        hi = 0;
        repeat (65530) begin
            step();
            hi += int'(tick[3]);
        end
        check_int("ch3_d65535_ticks", hi, 1);

        // Random enable/load/reset traffic on small divisors.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(499) != 0);
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(15) == 0) en[c] = ~en[c];
                load[c] = ($urandom_range(11) == 0);
                set_div(c, int'($urandom_range(9)));
            end
            step();
        end
        load = '0; rst_n = 1'b1;
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_clock_generator.md
MULTI_CLOCK_GENERATOR -- requirements
Module: multi_clock_generator

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent divided-clock channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 16, width of each channel divisor.
REQ-003 SHALL have parameter DIV_INIT, default 5000, divisor loaded into every channel at reset (50 MHz -> 10 kHz).
REQ-004 SHALL have port clk_in  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  input  N_CH  per-channel run enable.
REQ-007 SHALL have port load  input  N_CH  per-channel one-cycle divisor load strobe.
REQ-008 SHALL have port div_val  input  N_CH*DIV_W  per-channel divisor; channel i uses bits [i*DIV_W +: DIV_W].
REQ-009 SHALL have port clk_out  output  N_CH  per-channel divided clock, registered.
REQ-010 SHALL have port tick  output  N_CH  per-channel one-cycle pulse, high in the cycle clk_out[i] rises.
REQ-011 SHALL have port busy  output  N_CH  high while channel is running or finishing its last period.

Function
REQ-012 SHALL give each channel an active divisor D, a pending divisor P, a pending flag, a period counter cnt (0..D-1) and states IDLE, RUN, DRAIN.
REQ-013 SHALL, with active divisor D>=2 in RUN, produce period exactly D clk_in cycles: clk_out high for ceil(D/2) cycles, low for floor(D/2) cycles.
REQ-014 SHALL treat a loaded divisor of 1 as 2; a loaded divisor of 0 SHALL stop the channel (IDLE, clk_out low) at the next period boundary.
REQ-015 SHALL move IDLE -> RUN on the edge where en[i]=1 and D>=2; clk_out[i] and tick[i] high from the following cycle, cnt=0.
REQ-016 SHALL, on load[i]=1, capture div_val slice into P and set pending; a second load before the boundary overwrites P.
REQ-017 SHALL apply pending P to D only at a period boundary (cnt wrapping D-1 -> 0) in RUN/DRAIN, or immediately in IDLE; no truncated high or low phase ever.
REQ-018 SHALL move RUN -> DRAIN when en[i] falls; DRAIN completes the current period, then goes IDLE with clk_out low.
REQ-019 SHALL move DRAIN -> RUN without gap if en[i] returns high before the boundary.
REQ-020 SHALL drive busy[i]=1 in RUN and DRAIN, 0 in IDLE.
REQ-021 SHALL make channels fully independent; simultaneous load/en events on different channels do not interact.
REQ-022 SHALL give load priority over boundary: load and wrap in same cycle -> the newly captured value is applied at the following boundary, old P discarded.
REQ-023 SHALL use cnt width DIV_W, comparison against ceil(D/2) computed as (D+1)>>1 in DIV_W+1 bits (no overflow at D=2^DIV_W-1).

Reset
REQ-024 SHALL, on rst_n=0 at a rising clk_in edge, set every channel IDLE, D=P=DIV_INIT, pending=0, cnt=0, clk_out=0, tick=0, busy=0.
REQ-025 SHALL let reset mid-period abort immediately; en high after reset release restarts per REQ-015.
REQ-026 SHALL ignore en, load and div_val while rst_n=0.

Structure
REQ-027 SHALL place state encoding (IDLE/RUN/DRAIN) and DIV_INIT default in shared package clock_pkg.
REQ-028 SHALL implement one channel as sub-module clock_div_channel, instantiated N_CH times by generate loop.
REQ-029 SHALL contain no clock gating or use of clk_in as data; every output is a flop.

Verification
REQ-030 SHALL cover: DIV_INIT=5000, en[0]=1 -> clk_out[0] high 2500, low 2500 cycles, tick every 5000 cycles.
REQ-031 SHALL cover: load D=7 on channel 1 mid-period of D=4 -> current 4-cycle period completes, then 4 high/3 low repeating.
REQ-032 SHALL cover: en[2] falls at cnt=1 of D=6 -> 4 more cycles, then clk_out low, busy 0; en back at cnt=3 -> no gap.
REQ-033 SHALL cover: load D=0 -> stops at boundary; load D=1 -> period 2 (1 high/1 low).
REQ-034 SHALL cover: rst_n low for one cycle mid-high-phase -> all outputs 0 next cycle, D=DIV_INIT.
REQ-035 SHALL cover: all N_CH=4 channels with D=2,3,4,65535 simultaneously -> each period exact, independent.
